hazard_ctrl: RTL

- Central stall/flush controller for the 5-stage MIPS pipeline.
- Compares D-stage operand needs (Tuse) against E/M-stage result readiness (Tnew) and tracks the multiply/divide unit busy window with an internal countdown.
- Drives the write-enable and flush controls of the PC, F/D, D/E, E/M and M/W pipeline registers.
- One instance in the CPU top level, beside the pipeline registers.

---
 rtl/hazard_ctrl_pkg.sv | 49 ++++
 rtl/hazard_ctrl_mdu_busy_timer.sv | 42 ++++
 rtl/hazard_ctrl.sv | 109 ++++++++++
 3 files changed

// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_ctrl_pkg
//  Purpose  : Shared definitions for the pipeline hazard controller.
//             - Tuse/Tnew encodings (0..2 valid, 3 = never)
//             - Default multiply/divide busy windows
//             - Register-zero constant
//             - Per-source-operand hazard comparator helper
//  Revision : 1.0  initial release
// ============================================================================
package hazard_ctrl_pkg;

    // Tuse: cycles until D needs the operand.
    localparam logic [1:0] TUSE_0     = 2'd0;
    localparam logic [1:0] TUSE_1     = 2'd1;
    localparam logic [1:0] TUSE_2     = 2'd2;
    localparam logic [1:0] TUSE_NEVER = 2'd3;

    // Tnew: cycles until a producer's result can be forwarded.
    localparam logic [1:0] TNEW_0     = 2'd0;
    localparam logic [1:0] TNEW_1     = 2'd1;
    localparam logic [1:0] TNEW_2     = 2'd2;
    localparam logic [1:0] TNEW_NEVER = 2'd3;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // A source operand stalls when a younger-stage producer writes the same
    // register and its result will not be ready by the time D consumes it.
    // $zero is hard-wired and never produces a dependency.
    function automatic logic src_haz(
        input logic [4:0] src_addr,
        input logic [1:0] tuse,
        input logic [4:0] e_addr,
        input logic [1:0] e_tnew,
        input logic [4:0] m_addr,
        input logic [1:0] m_tnew
    );
        logic e_hit;
        logic m_hit;
        e_hit = (e_addr == src_addr) && (e_tnew > tuse);
        m_hit = (m_addr == src_addr) && (m_tnew > tuse);
        return (src_addr != REG_ZERO) && (e_hit || m_hit);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_mdu_busy_timer.sv
`default_nettype none
// ============================================================================
//  Module   : mdu_busy_timer
//  Purpose  : Countdown of the multiply/divide unit busy window.
//             A start loads the window length (later start wins, even while
//             busy); otherwise the counter decrements to zero and holds.
//  Ports    : clk, reset      - clock, synchronous active-high reset
//             md_start        - mult/div issued from E this cycle
//             md_div          - 1 = div window, 0 = mult window
//             mdu_busy        - counter non-zero
//  Revision : 1.0  initial release
// ============================================================================
module mdu_busy_timer
    import hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic md_start,
    input  logic md_div,
    output logic mdu_busy
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (md_start) begin
            r_cnt <= md_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign mdu_busy = (r_cnt != '0);

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_ctrl
//  Purpose  : Stall/flush controller for the 5-stage MIPS pipeline.
//             Compares D-stage Tuse against E/M-stage Tnew and tracks the
//             MDU busy window; drives pipeline-register enables/flushes.
//             All controls are combinational and act at the same clk edge.
//  Ports    : clk, reset                 - clock, sync active-high reset
//             D_rs_addr/D_rt_addr        - D source registers
//             D_tuse_rs/D_tuse_rt        - D operand Tuse (3 = unused)
//             D_is_md                    - D instruction touches the MDU
//             E_wr_addr/E_tnew           - E destination and Tnew
//             M_wr_addr/M_tnew           - M destination and Tnew
//             E_md_start/E_md_div        - MDU start in E, div qualifier
//             stall, pc_we, fd_we        - D hold, PC and F/D enables
//             de_flush                   - D/E bubble insert
//             em_we, mw_we               - E/M and M/W enables (always 1)
//             mdu_busy                   - MDU countdown active
//             stall_cycles, md_stall_cycles (HAZARD_STATS_EN only)
//  Config   : `define HAZARD_STATS_EN adds the two stall statistics counters.
//  Revision : 1.0  initial release
// ============================================================================
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  D_rs_addr,
    input  logic [4:0]  D_rt_addr,
    input  logic [1:0]  D_tuse_rs,
    input  logic [1:0]  D_tuse_rt,
    input  logic        D_is_md,
    input  logic [4:0]  E_wr_addr,
    input  logic [1:0]  E_tnew,
    input  logic [4:0]  M_wr_addr,
    input  logic [1:0]  M_tnew,
    input  logic        E_md_start,
    input  logic        E_md_div,
    output logic        stall,
    output logic        pc_we,
    output logic        fd_we,
    output logic        de_flush,
    output logic        em_we,
    output logic        mw_we,
`ifdef HAZARD_STATS_EN
    output logic [31:0] stall_cycles,
    output logic [31:0] md_stall_cycles,
`endif
    output logic        mdu_busy
);

    logic w_rs_haz;
    logic w_rt_haz;
    logic w_md_haz;

    mdu_busy_timer #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_mdu_busy_timer (
        .clk      (clk),
        .reset    (reset),
        .md_start (E_md_start),
        .md_div   (E_md_div),
        .mdu_busy (mdu_busy)
    );

    assign w_rs_haz = src_haz(D_rs_addr, D_tuse_rs, E_wr_addr, E_tnew, M_wr_addr, M_tnew);
    assign w_rt_haz = src_haz(D_rt_addr, D_tuse_rt, E_wr_addr, E_tnew, M_wr_addr, M_tnew);

    // The start cycle itself is covered by E_md_start because the counter
    // only becomes non-zero after the edge that loads it.
    assign w_md_haz = D_is_md & (mdu_busy | E_md_start);

    assign stall    = w_rs_haz | w_rt_haz | w_md_haz;
    assign pc_we    = ~stall;
    assign fd_we    = ~stall;
    assign de_flush = stall;
    assign em_we    = 1'b1;
    assign mw_we    = 1'b1;

`ifdef HAZARD_STATS_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_md_stall_cycles;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cycles    <= '0;
            r_md_stall_cycles <= '0;
        end else begin
            if (stall) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (w_md_haz) begin
                r_md_stall_cycles <= r_md_stall_cycles + 32'd1;
            end
        end
    end

    assign stall_cycles    = r_stall_cycles;
    assign md_stall_cycles = r_md_stall_cycles;
`endif

endmodule
`default_nettype wire
